axil_memory_arbiter: RTL and testbench
======================================

# axil_memory_arbiter

Two-to-one AXI4-Lite arbiter that lets the CPU's instruction-fetch port and data-memory port share a single memory slave, such as the memory controller behind calibration. Each granted transaction runs to completion before the next one starts, and only one transaction is outstanding at any time. Arbitration is round-robin between the two ports. The instruction port is read-only.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width; WSTRB width is DATA_WIDTH/8

Ports:
- i_Clock  in  1  single clock; all logic on the rising edge
- i_Reset  in  1  asynchronous, active-high reset
- s_instr_axil_ar{addr,valid,ready}  in/in/out  ADDR_WIDTH/1/1  instruction read-address channel
- s_instr_axil_r{data,valid,ready}  out/out/in  DATA_WIDTH/1/1  instruction read-data channel
- s_data_axil_ar{addr,valid,ready}  in/in/out  ADDR_WIDTH/1/1  data read-address channel
- s_data_axil_r{data,valid,ready}  out/out/in  DATA_WIDTH/1/1  data read-data channel
- s_data_axil_aw{addr,valid,ready}  in/in/out  ADDR_WIDTH/1/1  data write-address channel
- s_data_axil_w{data,strb,valid,ready}  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  data write-data channel
- s_data_axil_b{resp,valid,ready}  out/out/in  2/1/1  data write-response channel
- m_axil_ar{addr,valid,ready}  out/out/in  ADDR_WIDTH/1/1  shared read-address channel
- m_axil_r{data,valid,ready}  in/in/out  DATA_WIDTH/1/1  shared read-data channel
- m_axil_aw{addr,valid,ready}  out/out/in  ADDR_WIDTH/1/1  shared write-address channel
- m_axil_w{data,strb,valid,ready}  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  shared write-data channel
- m_axil_b{resp,valid,ready}  in/in/out  2/1/1  shared write-response channel

## Operation

**States:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.

**Requests, evaluated in IDLE only:**
- Instruction request (IR): s_instr arvalid.
- Data request (DR): s_data (awvalid && wvalid), or else s_data arvalid.
- Within the data port, a write wins over a read when both are present.
- A data write requires AW and W valid in the same cycle. A lone AW or lone W is not a request.

**Arbitration:**
- If only one of IR/DR is present, it wins.
- If both are present, the port not granted last wins.
- The last-grant pointer updates on every grant and resets to "instruction", so data wins the first conflict.

**Grant (IDLE):**
- The winner's arready, or awready+wready, is driven high combinationally in that cycle.
- addr, data and strb are latched at the edge, together with the owner ID.
- Next state is RD_ADDR or WR_REQ.

**RD_ADDR:**
- m_arvalid=1 with the latched address.
- On m_arready → RD_DATA.

**RD_DATA:**
- m_rdata is fed combinationally to the owner's rdata.
- m_rvalid is routed to the owner's rvalid only; the other port's rvalid stays 0.
- m_rready = owner's rready.
- On the m_rvalid && m_rready handshake → IDLE.

**WR_REQ:**
- m_awvalid and m_wvalid are raised together.
- Each deasserts independently after its own ready handshake.
- When both have handshaken (same or different cycles) → WR_RESP.

**WR_RESP:**
- m_bvalid/m_bresp are routed to s_data; m_bready = s_data bready.
- On the handshake → IDLE.

**Always:**
- Non-owner ready and valid outputs stay 0.
- rresp is not forwarded.
- Addresses and data pass unmodified; there is no address decode.

## Timing

**Reset:**
- All valid/ready outputs are 0; addr/data/strb outputs are 0.
- Asynchronous assertion forces IDLE immediately.
- An in-flight transaction is abandoned, so the downstream slave must share the reset.
- Pointer resets to "instruction".

**Latency:**
- Request accepted in cycle N → m_arvalid/m_awvalid high from N+1.
- Response handshake in cycle M → earliest next grant in M+1.
- Back-to-back reads with a zero-wait slave: 3 cycles per transaction (grant, addr, data).

**Handshake rules:**
- Master valids never drop before their ready.
- Latched payload is stable while valid is high.

**Simultaneous events:** a request arriving in the cycle a transaction completes is not granted until the next IDLE cycle.

## Test plan
- Instr read 0x0000_0010, slave returns 0x0000_0013 with zero wait → m_araddr=0x10 at N+1; s_instr_rdata=0x13 with rvalid in N+2; s_data outputs remain 0.
- Instr read and data read (0x8000_0004) both asserted in the same IDLE cycle after reset → data granted first, instruction next; then a second simultaneous pair → instruction first.
- Data write addr 0x8000_0000, data 0xDEADBEEF, strb 0xF; slave raises awready at +1 and wready at +3 → m_awvalid drops after +1, m_wvalid held to +3, WR_RESP follows; bresp=2'b00 forwarded to s_data.
- Data AW and AR both valid with W low → the read is granted and s_data awready stays 0; then AW+W valid → the write is granted.
- i_Reset asserted in RD_DATA with m_rvalid held low → all outputs 0 immediately; after release, a fresh instr read completes normally.
- Owner rready held low for 4 cycles while m_rvalid=1 → m_rready=0 throughout, state holds RD_DATA, and rdata stays stable until the handshake.

Source files
------------

// File: rtl/axil_memory_arbiter.sv
// rtl/axil_memory_arbiter.sv - two-to-one AXI4-Lite arbiter, instruction read port and data port onto one slave
// One transaction in flight at a time; round-robin between the two ports on conflict.
module axil_memory_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset,

   input  logic [ADDR_WIDTH-1:0]     s_instr_axil_araddr,
   input  logic                      s_instr_axil_arvalid,
   output logic                      s_instr_axil_arready,
   output logic [DATA_WIDTH-1:0]     s_instr_axil_rdata,
   output logic                      s_instr_axil_rvalid,
   input  logic                      s_instr_axil_rready,

   input  logic [ADDR_WIDTH-1:0]     s_data_axil_araddr,
   input  logic                      s_data_axil_arvalid,
   output logic                      s_data_axil_arready,
   output logic [DATA_WIDTH-1:0]     s_data_axil_rdata,
   output logic                      s_data_axil_rvalid,
   input  logic                      s_data_axil_rready,
   input  logic [ADDR_WIDTH-1:0]     s_data_axil_awaddr,
   input  logic                      s_data_axil_awvalid,
   output logic                      s_data_axil_awready,
   input  logic [DATA_WIDTH-1:0]     s_data_axil_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_data_axil_wstrb,
   input  logic                      s_data_axil_wvalid,
   output logic                      s_data_axil_wready,
   output logic [1:0]                s_data_axil_bresp,
   output logic                      s_data_axil_bvalid,
   input  logic                      s_data_axil_bready,

   output logic [ADDR_WIDTH-1:0]     m_axil_araddr,
   output logic                      m_axil_arvalid,
   input  logic                      m_axil_arready,
   input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
   input  logic                      m_axil_rvalid,
   output logic                      m_axil_rready,
   output logic [ADDR_WIDTH-1:0]     m_axil_awaddr,
   output logic                      m_axil_awvalid,
   input  logic                      m_axil_awready,
   output logic [DATA_WIDTH-1:0]     m_axil_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
   output logic                      m_axil_wvalid,
   input  logic                      m_axil_wready,
   input  logic [1:0]                m_axil_bresp,
   input  logic                      m_axil_bvalid,
   output logic                      m_axil_bready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

   state_t                  state, state_next;
   logic                    owner_data;
   logic                    last_data;
   logic                    aw_done, w_done;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [STRB_WIDTH-1:0]   wstrb_q;

   logic                    data_write, data_req;
   logic                    grant_data, grant_instr;

   // A lone AW or lone W never counts as a write request.
   assign data_write = s_data_axil_awvalid && s_data_axil_wvalid;
   assign data_req   = data_write || s_data_axil_arvalid;

   assign m_axil_araddr = addr_q;
   assign m_axil_awaddr = addr_q;
   assign m_axil_wdata  = wdata_q;
   assign m_axil_wstrb  = wstrb_q;

   always_comb begin
      state_next           = state;
      grant_data           = 1'b0;
      grant_instr          = 1'b0;
      s_instr_axil_arready = 1'b0;
      s_instr_axil_rdata   = '0;
      s_instr_axil_rvalid  = 1'b0;
      s_data_axil_arready  = 1'b0;
      s_data_axil_rdata    = '0;
      s_data_axil_rvalid   = 1'b0;
      s_data_axil_awready  = 1'b0;
      s_data_axil_wready   = 1'b0;
      s_data_axil_bresp    = 2'b00;
      s_data_axil_bvalid   = 1'b0;
      m_axil_arvalid       = 1'b0;
      m_axil_rready        = 1'b0;
      m_axil_awvalid       = 1'b0;
      m_axil_wvalid        = 1'b0;
      m_axil_bready        = 1'b0;

      case (state)
         IDLE: begin
            // Data wins when alone or when instruction held the last grant.
            if (data_req && (!s_instr_axil_arvalid || !last_data)) begin
               grant_data = 1'b1;
               if (data_write) begin
                  s_data_axil_awready = 1'b1;
                  s_data_axil_wready  = 1'b1;
                  state_next          = WR_REQ;
               end else begin
                  s_data_axil_arready = 1'b1;
                  state_next          = RD_ADDR;
               end
            end else if (s_instr_axil_arvalid) begin
               grant_instr          = 1'b1;
               s_instr_axil_arready = 1'b1;
               state_next           = RD_ADDR;
            end
         end
         RD_ADDR: begin
            m_axil_arvalid = 1'b1;
            if (m_axil_arready)
               state_next = RD_DATA;
         end
         RD_DATA: begin
            if (owner_data) begin
               s_data_axil_rdata  = m_axil_rdata;
               s_data_axil_rvalid = m_axil_rvalid;
               m_axil_rready      = s_data_axil_rready;
            end else begin
               s_instr_axil_rdata  = m_axil_rdata;
               s_instr_axil_rvalid = m_axil_rvalid;
               m_axil_rready       = s_instr_axil_rready;
            end
            if (m_axil_rvalid && m_axil_rready)
               state_next = IDLE;
         end
         WR_REQ: begin
            m_axil_awvalid = !aw_done;
            m_axil_wvalid  = !w_done;
            if ((aw_done || m_axil_awready) && (w_done || m_axil_wready))
               state_next = WR_RESP;
         end
         WR_RESP: begin
            s_data_axil_bvalid = m_axil_bvalid;
            s_data_axil_bresp  = m_axil_bresp;
            m_axil_bready      = s_data_axil_bready;
            if (m_axil_bvalid && s_data_axil_bready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state      <= IDLE;
         owner_data <= 1'b0;
         last_data  <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
      end else begin
         state <= state_next;
         if (grant_data || grant_instr) begin
            owner_data <= grant_data;
            last_data  <= grant_data;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            if (grant_instr) begin
               addr_q <= s_instr_axil_araddr;
            end else if (data_write) begin
               addr_q  <= s_data_axil_awaddr;
               wdata_q <= s_data_axil_wdata;
               wstrb_q <= s_data_axil_wstrb;
            end else begin
               addr_q <= s_data_axil_araddr;
            end
         end
         if (state == WR_REQ) begin
            if (m_axil_awvalid && m_axil_awready) aw_done <= 1'b1;
            if (m_axil_wvalid && m_axil_wready)   w_done  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axil_memory_arbiter.sv
// tb/tb_axil_memory_arbiter.sv - directed self-checking bench for axil_memory_arbiter
module tb_axil_memory_arbiter;

   logic        i_Clock = 1'b0;
   logic        i_Reset = 1'b1;
   logic [31:0] s_instr_axil_araddr, s_instr_axil_rdata;
   logic        s_instr_axil_arvalid, s_instr_axil_arready, s_instr_axil_rvalid, s_instr_axil_rready;
   logic [31:0] s_data_axil_araddr, s_data_axil_rdata, s_data_axil_awaddr, s_data_axil_wdata;
   logic        s_data_axil_arvalid, s_data_axil_arready, s_data_axil_rvalid, s_data_axil_rready;
   logic        s_data_axil_awvalid, s_data_axil_awready, s_data_axil_wvalid, s_data_axil_wready;
   logic [3:0]  s_data_axil_wstrb;
   logic [1:0]  s_data_axil_bresp;
   logic        s_data_axil_bvalid, s_data_axil_bready;
   logic [31:0] m_axil_araddr, m_axil_rdata, m_axil_awaddr, m_axil_wdata;
   logic        m_axil_arvalid, m_axil_arready, m_axil_rvalid, m_axil_rready;
   logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
   logic [3:0]  m_axil_wstrb;
   logic [1:0]  m_axil_bresp;
   logic        m_axil_bvalid, m_axil_bready;

   int tests = 0;
   int fails = 0;

   axil_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .i_Clock(i_Clock), .i_Reset(i_Reset),
      .s_instr_axil_araddr(s_instr_axil_araddr), .s_instr_axil_arvalid(s_instr_axil_arvalid),
      .s_instr_axil_arready(s_instr_axil_arready), .s_instr_axil_rdata(s_instr_axil_rdata),
      .s_instr_axil_rvalid(s_instr_axil_rvalid), .s_instr_axil_rready(s_instr_axil_rready),
      .s_data_axil_araddr(s_data_axil_araddr), .s_data_axil_arvalid(s_data_axil_arvalid),
      .s_data_axil_arready(s_data_axil_arready), .s_data_axil_rdata(s_data_axil_rdata),
      .s_data_axil_rvalid(s_data_axil_rvalid), .s_data_axil_rready(s_data_axil_rready),
      .s_data_axil_awaddr(s_data_axil_awaddr), .s_data_axil_awvalid(s_data_axil_awvalid),
      .s_data_axil_awready(s_data_axil_awready), .s_data_axil_wdata(s_data_axil_wdata),
      .s_data_axil_wstrb(s_data_axil_wstrb), .s_data_axil_wvalid(s_data_axil_wvalid),
      .s_data_axil_wready(s_data_axil_wready), .s_data_axil_bresp(s_data_axil_bresp),
      .s_data_axil_bvalid(s_data_axil_bvalid), .s_data_axil_bready(s_data_axil_bready),
      .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
      .m_axil_rdata(m_axil_rdata), .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
      .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
      .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
      .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
      .m_axil_bready(m_axil_bready)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge i_Clock);
      #1;
   endtask

   // Called one cycle after a read grant; zero-wait slave returns rdata.
   task automatic serve_read(input logic exp_data_owner, input logic [31:0] exp_addr, input logic [31:0] rdata);
      m_axil_arready = 1'b1;
      #1;
      check("rd_arvalid", m_axil_arvalid, 1'b1);
      check("rd_araddr", m_axil_araddr, exp_addr);
      tick();
      m_axil_arready = 1'b0;
      m_axil_rvalid  = 1'b1;
      m_axil_rdata   = rdata;
      s_instr_axil_rready = 1'b1;
      s_data_axil_rready  = 1'b1;
      #1;
      check("rd_arvalid_low", m_axil_arvalid, 1'b0);
      check("rd_data_rvalid", s_data_axil_rvalid, exp_data_owner);
      check("rd_instr_rvalid", s_instr_axil_rvalid, !exp_data_owner);
      check("rd_data_rdata", s_data_axil_rdata, exp_data_owner ? rdata : 32'h0);
      check("rd_instr_rdata", s_instr_axil_rdata, exp_data_owner ? 32'h0 : rdata);
      tick();
      m_axil_rvalid = 1'b0;
      s_instr_axil_rready = 1'b0;
      s_data_axil_rready  = 1'b0;
   endtask

   initial begin
      s_instr_axil_araddr = '0; s_instr_axil_arvalid = 0; s_instr_axil_rready = 0;
      s_data_axil_araddr = '0; s_data_axil_arvalid = 0; s_data_axil_rready = 0;
      s_data_axil_awaddr = '0; s_data_axil_awvalid = 0; s_data_axil_wdata = '0;
      s_data_axil_wstrb = '0; s_data_axil_wvalid = 0; s_data_axil_bready = 0;
      m_axil_arready = 0; m_axil_rdata = '0; m_axil_rvalid = 0; m_axil_awready = 0;
      m_axil_wready = 0; m_axil_bresp = 2'b00; m_axil_bvalid = 0;

      // Reset state
      tick();
      check("rst_arvalid", m_axil_arvalid, 1'b0);
      check("rst_awvalid", m_axil_awvalid, 1'b0);
      check("rst_wvalid", m_axil_wvalid, 1'b0);
      check("rst_araddr", m_axil_araddr, 32'h0);
      check("rst_wstrb", m_axil_wstrb, 4'h0);
      tick();
      i_Reset = 1'b0;
      tick();

      // Simultaneous reads: data first, then instruction, then data alone
      s_instr_axil_arvalid = 1; s_instr_axil_araddr = 32'h0000_0100;
      s_data_axil_arvalid  = 1; s_data_axil_araddr  = 32'h8000_0004;
      #1;
      check("arb1_data_arready", s_data_axil_arready, 1'b1);
      check("arb1_instr_arready", s_instr_axil_arready, 1'b0);
      tick();
      s_data_axil_araddr = 32'h8000_0008;
      serve_read(1'b1, 32'h8000_0004, 32'hAAAA_0001);
      #1;
      check("arb2_instr_arready", s_instr_axil_arready, 1'b1);
      check("arb2_data_arready", s_data_axil_arready, 1'b0);
      tick();
      s_instr_axil_arvalid = 0;
      serve_read(1'b0, 32'h0000_0100, 32'hBBBB_0002);
      #1;
      check("arb3_data_arready", s_data_axil_arready, 1'b1);
      tick();
      s_data_axil_arvalid = 0;
      serve_read(1'b1, 32'h8000_0008, 32'hCCCC_0003);

      // Instruction read, zero-wait slave
      s_instr_axil_arvalid = 1; s_instr_axil_araddr = 32'h0000_0010;
      #1;
      check("ir_arready", s_instr_axil_arready, 1'b1);
      tick();
      s_instr_axil_arvalid = 0;
      serve_read(1'b0, 32'h0000_0010, 32'h0000_0013);

      // Data write with awready at +1 and wready at +3
      s_data_axil_awvalid = 1; s_data_axil_awaddr = 32'h8000_0000;
      s_data_axil_wvalid = 1; s_data_axil_wdata = 32'hDEAD_BEEF; s_data_axil_wstrb = 4'hF;
      #1;
      check("wr_awready", s_data_axil_awready, 1'b1);
      check("wr_wready", s_data_axil_wready, 1'b1);
      tick();
      s_data_axil_awvalid = 0; s_data_axil_wvalid = 0;
      m_axil_awready = 1;
      #1;
      check("wr1_awvalid", m_axil_awvalid, 1'b1);
      check("wr1_wvalid", m_axil_wvalid, 1'b1);
      check("wr1_awaddr", m_axil_awaddr, 32'h8000_0000);
      check("wr1_wdata", m_axil_wdata, 32'hDEAD_BEEF);
      check("wr1_wstrb", m_axil_wstrb, 4'hF);
      tick();
      m_axil_awready = 0;
      #1;
      check("wr2_awvalid", m_axil_awvalid, 1'b0);
      check("wr2_wvalid", m_axil_wvalid, 1'b1);
      tick();
      m_axil_wready = 1;
      #1;
      check("wr3_wvalid", m_axil_wvalid, 1'b1);
      tick();
      m_axil_wready = 0;
      m_axil_bvalid = 1; m_axil_bresp = 2'b00; s_data_axil_bready = 1;
      #1;
      check("wr4_wvalid", m_axil_wvalid, 1'b0);
      check("wr4_bvalid", s_data_axil_bvalid, 1'b1);
      check("wr4_bresp", s_data_axil_bresp, 2'b00);
      check("wr4_bready", m_axil_bready, 1'b1);
      tick();
      m_axil_bvalid = 0; s_data_axil_bready = 0;
      #1;
      check("wr5_bvalid_low", s_data_axil_bvalid, 1'b0);

      // AW and AR with W low: read wins, then AW+W write
      s_data_axil_awvalid = 1; s_data_axil_awaddr = 32'h0000_0040;
      s_data_axil_arvalid = 1; s_data_axil_araddr = 32'h0000_0044;
      #1;
      check("awar_arready", s_data_axil_arready, 1'b1);
      check("awar_awready", s_data_axil_awready, 1'b0);
      tick();
      s_data_axil_arvalid = 0;
      serve_read(1'b1, 32'h0000_0044, 32'h1111_2222);
      s_data_axil_wvalid = 1; s_data_axil_wdata = 32'h0000_1234; s_data_axil_wstrb = 4'h3;
      #1;
      check("aw2_awready", s_data_axil_awready, 1'b1);
      check("aw2_wready", s_data_axil_wready, 1'b1);
      tick();
      s_data_axil_awvalid = 0; s_data_axil_wvalid = 0;
      m_axil_awready = 1; m_axil_wready = 1;
      #1;
      check("aw2_awaddr", m_axil_awaddr, 32'h0000_0040);
      check("aw2_wdata", m_axil_wdata, 32'h0000_1234);
      check("aw2_wstrb", m_axil_wstrb, 4'h3);
      tick();
      m_axil_awready = 0; m_axil_wready = 0;
      m_axil_bvalid = 1; m_axil_bresp = 2'b10; s_data_axil_bready = 1;
      #1;
      check("aw2_bresp", s_data_axil_bresp, 2'b10);
      check("aw2_instr_rvalid", s_instr_axil_rvalid, 1'b0);
      tick();
      m_axil_bvalid = 0; m_axil_bresp = 2'b00; s_data_axil_bready = 0;

      // Reset during RD_DATA with rvalid low
      s_instr_axil_arvalid = 1; s_instr_axil_araddr = 32'h0000_0200;
      tick();
      s_instr_axil_arvalid = 0;
      m_axil_arready = 1;
      tick();
      m_axil_arready = 0;
      s_instr_axil_rready = 1;
      #1;
      check("rstrd_rready_pre", m_axil_rready, 1'b1);
      i_Reset = 1'b1;
      #1;
      check("rstrd_rready", m_axil_rready, 1'b0);
      check("rstrd_araddr", m_axil_araddr, 32'h0);
      check("rstrd_arvalid", m_axil_arvalid, 1'b0);
      tick();
      i_Reset = 1'b0;
      s_instr_axil_rready = 0;
      tick();
      s_instr_axil_arvalid = 1; s_instr_axil_araddr = 32'h0000_0300;
      #1;
      check("postrst_arready", s_instr_axil_arready, 1'b1);
      tick();
      s_instr_axil_arvalid = 0;
      serve_read(1'b0, 32'h0000_0300, 32'h0303_0303);

      // Owner rready low for 4 cycles while rvalid high
      s_instr_axil_arvalid = 1; s_instr_axil_araddr = 32'h0000_0400;
      tick();
      s_instr_axil_arvalid = 0;
      m_axil_arready = 1;
      tick();
      m_axil_arready = 0;
      m_axil_rvalid = 1; m_axil_rdata = 32'h5555_AAAA; s_instr_axil_rready = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("stall_rready", m_axil_rready, 1'b0);
         check("stall_rvalid", s_instr_axil_rvalid, 1'b1);
         check("stall_rdata", s_instr_axil_rdata, 32'h5555_AAAA);
         tick();
      end
      s_instr_axil_rready = 1;
      #1;
      check("stall_rready_go", m_axil_rready, 1'b1);
      tick();
      m_axil_rvalid = 0; s_instr_axil_rready = 0;
      #1;
      check("stall_done_rvalid", s_instr_axil_rvalid, 1'b0);
      check("stall_done_rready", m_axil_rready, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
